instr_fetch_unit: RTL and testbench

Downstream stage of the instruction load counter. It waits for the program-memory preload to finish (load_done), then owns the program-memory read port. It sequences the program counter, performs synchronous reads and presents each instruction to the decoder over a valid/ready handshake. It also handles branch redirects, halt, and a retired-instruction count.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_sat_counter.sv | 34 +++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: state encodings and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int IFU_PC_W    = 8;
  localparam int IFU_ADDR_W  = 9;
  localparam int IFU_INSTR_W = 16;
  localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = '0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter for performance/retire statistics.
// Latency: count reflects an inc pulse one cycle after the edge that samples it.
// Backpressure: none; increments past all-ones are dropped (count holds).
// Ports: clk, rst (sync, active-low), inc (count enable), count (W-bit value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequences PC, reads program memory, hands words to the decoder.
// Latency: read issued 1 cycle after entering REQ; instr_valid 2 cycles after imem_en; 3 cycles/instr at best.
// Backpressure: instr_valid/instr_ready; instr and instr_pc hold in HOLD until accepted, no reads issued meanwhile.
// Ports: clk, rst (sync active-low), load_done (memory handed over), imem_en/imem_addr/imem_rdata
//        (sync-read memory port), instr/instr_pc/instr_valid/instr_ready (decoder handshake),
//        redirect_valid/redirect_target (branch), halt/halted, retired_count (saturating).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W    = IFU_PC_W,
  parameter int ADDR_W  = IFU_ADDR_W,
  parameter int INSTR_W = IFU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_done,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               halt,
  output logic               halted,
  output logic [15:0]        retired_count
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               retire;

  // A held instruction retires whenever the decoder takes it, even if a halt or
  // redirect arrives in the same cycle; only losing the memory cancels it.
  assign retire = (state_q == ST_HOLD) && instr_ready && load_done;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (load_done) begin
          state_d = ST_REQ;
          pc_d    = RESET_PC;
        end
      end
      // HALT is sticky until reset; the memory port is already idle there,
      // so a load_done drop needs no action.
      ST_HALT: state_d = ST_HALT;
      default: begin
        if (!load_done) begin
          state_d = ST_IDLE;
          pc_d    = RESET_PC;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          // Any read in flight belongs to the old path: restart from target.
          state_d = ST_REQ;
          pc_d    = redirect_target;
        end else begin
          case (state_q)
            ST_REQ:  state_d = ST_RESP;
            ST_RESP: begin
              instr_d    = imem_rdata;
              instr_pc_d = pc_q;
              state_d    = ST_HOLD;
            end
            ST_HOLD: begin
              if (instr_ready) begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_REQ;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Gated by load_done combinationally so the port releases in the very cycle
  // the loader takes the memory back.
  assign imem_en     = (state_q == ST_REQ) && load_done;
  assign imem_addr   = {{(ADDR_W-PC_W){1'b0}}, pc_q};
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign halted      = (state_q == ST_HALT);

  sat_counter #(.W(16)) u_retired (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (retired_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous-read program memory.
// Latency: n/a.
// Backpressure: decoder ready driven directly from the stimulus.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_done;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        halt;
  logic        halted;
  logic [15:0] retired_count;

  logic        sc_rst;
  logic        sc_inc;
  logic [3:0]  sc_count;

  logic [15:0] mem [0:511];

  int total = 0;
  int bad   = 0;
  int saw_en;
  int saw_vld;
  int saw_chg;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .load_done       (load_done),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .halted          (halted),
    .retired_count   (retired_count)
  );

  // Narrow instance so saturation is reachable in a few cycles.
  sat_counter #(.W(4)) u_sc (
    .clk   (clk),
    .rst   (sc_rst),
    .inc   (sc_inc),
    .count (sc_count)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
    imem_rdata      = '0;
    rst             = 1'b0;
    load_done       = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt            = 1'b0;
    sc_rst          = 1'b0;
    sc_inc          = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_en",      imem_en, 0);
    check("rst_vld",     instr_valid, 0);
    check("rst_halted",  halted, 0);
    check("rst_retired", retired_count, 0);
    check("rst_instr",   instr, 0);
    check("rst_pc",      instr_pc, 0);
    rst = 1'b1;

    // 1: idle while memory is being loaded
    saw_en = 0; saw_vld = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_en) saw_en++;
      if (instr_valid) saw_vld++;
    end
    check("idle_en", saw_en, 0);
    check("idle_vld", saw_vld, 0);
    load_done = 1'b1;
    #1 check("ld_en_same", imem_en, 0);
    tick();
    check("first_en", imem_en, 1);
    check("first_addr", imem_addr, 9'h000);
    tick();
    check("first_resp_vld", instr_valid, 0);
    tick();
    check("first_vld", instr_valid, 1);
    check("first_instr", instr, 16'h1000);
    check("first_pc", instr_pc, 0);

    // 2: streaming with ready high, one word per 3 cycles
    instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (3) tick();
      check("stream_vld", instr_valid, 1);
      check("stream_instr", instr, 16'h1000 + 16'(k));
      check("stream_pc", instr_pc, 8'(k));
    end
    tick();
    check("retired5", retired_count, 5);
    instr_ready = 1'b0;

    // 3: stall in HOLD
    tick(); tick();
    check("stall_vld", instr_valid, 1);
    saw_en = 0; saw_chg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_en) saw_en++;
      if (instr !== 16'h1005 || instr_pc !== 8'h05 || instr_valid !== 1'b1) saw_chg++;
    end
    check("stall_en", saw_en, 0);
    check("stall_stable", saw_chg, 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("stall_retire", retired_count, 6);
    tick(); tick();
    check("stall_next_pc", instr_pc, 6);
    check("stall_one_retire", retired_count, 6);

    // 4: redirect in RESP drops the captured word
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pre_redir_retired", retired_count, 7);
    tick();
    redirect_valid = 1'b1; redirect_target = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_vld", instr_valid, 0);
    check("redir_addr", imem_addr, 9'h040);
    check("redir_en", imem_en, 1);
    tick(); tick();
    check("redir_pc", instr_pc, 8'h40);
    check("redir_instr", instr, 16'h1040);
    check("redir_retired", retired_count, 7);

    // redirect with ready in HOLD: retires, jumps to target (also hits wrap)
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check("redir_rdy_retired", retired_count, 8);
    check("redir_rdy_addr", imem_addr, 9'h0FF);
    tick(); tick();
    check("pc255", instr_pc, 8'hFF);
    check("instr255", instr, 16'h10FF);
    tick();
    check("wrap_addr", imem_addr, 9'h000);
    check("wrap_retired", retired_count, 9);
    tick(); tick();
    instr_ready = 1'b0;
    check("wrap_pc", instr_pc, 8'h00);
    check("wrap_instr", instr, 16'h1000);

    // 5: halt beats redirect, halt is sticky
    halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h20;
    tick();
    halt = 1'b0; redirect_target = 8'h30;
    check("halted", halted, 1);
    check("halt_en", imem_en, 0);
    check("halt_vld", instr_valid, 0);
    check("halt_retired", retired_count, 9);
    saw_en = 0; saw_vld = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      redirect_valid = 1'b0;
      if (imem_en) saw_en++;
      if (!halted) saw_vld++;
    end
    check("halt_sticky_en", saw_en, 0);
    check("halt_sticky", saw_vld, 0);
    rst = 1'b0;
    tick();
    check("rst2_halted", halted, 0);
    check("rst2_retired", retired_count, 0);
    check("rst2_instr", instr, 0);
    check("rst2_pc", instr_pc, 0);
    check("rst2_vld", instr_valid, 0);
    check("rst2_en", imem_en, 0);
    rst = 1'b1;

    // 6: load_done drop mid-fetch
    tick();
    check("refetch_en", imem_en, 1);
    load_done = 1'b0;
    #1 check("drop_en_same", imem_en, 0);
    saw_en = 0; saw_vld = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_en) saw_en++;
      if (instr_valid) saw_vld++;
    end
    check("drop_en", saw_en, 0);
    check("drop_vld", saw_vld, 0);
    load_done = 1'b1;
    tick();
    check("restart_en", imem_en, 1);
    check("restart_addr", imem_addr, 9'h000);
    tick(); tick();
    check("restart_pc", instr_pc, 0);
    check("restart_instr", instr, 16'h1000);

    // saturation on a narrow counter
    sc_rst = 1'b1;
    sc_inc = 1'b1;
    repeat (15) tick();
    check("sat_reach", sc_count, 4'hF);
    repeat (5) tick();
    check("sat_hold", sc_count, 4'hF);
    sc_inc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
